rom_port_arbiter: RTL and testbench

- Shares the single read port of the instruction ROM between two requesters:
  - instruction fetch (IF)
  - data-side reader (DR), used for constant and table loads from ROM.
- Sits between the fetch stage, the load/store unit and the ROM.
- Fetch has fixed priority; a starvation counter bounds how long DR can wait.
- Responses are registered, so each requester sees read data exactly one cycle after its handshake.

---
 rtl/rom_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_rom_port_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
//   Shares the single read port of the instruction ROM between instruction
//   fetch (IF) and the data-side reader (DR). Fetch has fixed priority; a
//   starvation counter forces a DR grant after STARVE_MAX consecutive
//   refusals. Responses are registered and appear one cycle after the
//   handshake (req & ready).
//
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   if_req/if_addr       fetch request and byte address (held until ready)
//   if_ready             combinational grant to fetch
//   if_rvalid/if_rdata/if_err  registered fetch response
//   dr_req/dr_addr       data-read request and byte address
//   dr_ready             combinational grant to data reader
//   dr_rvalid/dr_rdata/dr_err  registered data-read response
//   rom_addr             byte address to ROM (word index is addr[16:2])
//   rom_data             combinational ROM read data
module rom_port_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              dr_req,
  input  logic [ADDR_W-1:0] dr_addr,
  output logic              dr_ready,
  output logic              dr_rvalid,
  output logic [DATA_W-1:0] dr_rdata,
  output logic              dr_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // A word access is misaligned when either low byte-offset bit is set.
  function automatic logic misaligned(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  logic             grant_if_s;
  logic             grant_dr_s;
  logic [CNT_W-1:0] starve_cnt_r;

  logic              if_rvalid_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic              if_err_r;
  logic              dr_rvalid_r;
  logic [DATA_W-1:0] dr_rdata_r;
  logic              dr_err_r;

  // Arbitration: saturated starvation counter beats fetch priority.
  always_comb begin
    grant_if_s = 1'b0;
    grant_dr_s = 1'b0;
    if (reset) begin
      grant_if_s = 1'b0;
      grant_dr_s = 1'b0;
    end else if (dr_req && (starve_cnt_r == STARVE_LIM)) begin
      grant_dr_s = 1'b1;
    end else if (if_req) begin
      grant_if_s = 1'b1;
    end else if (dr_req) begin
      grant_dr_s = 1'b1;
    end else begin
      grant_if_s = 1'b0;
      grant_dr_s = 1'b0;
    end
  end

  // ROM address mux: winner's address, zero when idle.
  always_comb begin
    rom_addr = {ADDR_W{1'b0}};
    if (grant_if_s) begin
      rom_addr = if_addr;
    end else if (grant_dr_s) begin
      rom_addr = dr_addr;
    end else begin
      rom_addr = {ADDR_W{1'b0}};
    end
  end

  assign if_ready = grant_if_s;
  assign dr_ready = grant_dr_s;

  // Starvation counter: counts consecutive cycles DR is refused by fetch.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (dr_req && grant_if_s) begin
      // Saturation is unreachable here (saturated DR wins), kept as a guard.
      if (starve_cnt_r != STARVE_LIM) begin
        starve_cnt_r <= starve_cnt_r + CNT_ONE;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end
  end

  // Response registers: loser keeps its previous data/err, only rvalid drops.
  always_ff @(posedge clock) begin
    if (reset) begin
      if_rvalid_r <= 1'b0;
      if_rdata_r  <= {DATA_W{1'b0}};
      if_err_r    <= 1'b0;
      dr_rvalid_r <= 1'b0;
      dr_rdata_r  <= {DATA_W{1'b0}};
      dr_err_r    <= 1'b0;
    end else begin
      if_rvalid_r <= grant_if_s;
      dr_rvalid_r <= grant_dr_s;
      if (grant_if_s) begin
        if_rdata_r <= misaligned(if_addr) ? {DATA_W{1'b0}} : rom_data;
        if_err_r   <= misaligned(if_addr);
      end else begin
        if_rdata_r <= if_rdata_r;
        if_err_r   <= if_err_r;
      end
      if (grant_dr_s) begin
        dr_rdata_r <= misaligned(dr_addr) ? {DATA_W{1'b0}} : rom_data;
        dr_err_r   <= misaligned(dr_addr);
      end else begin
        dr_rdata_r <= dr_rdata_r;
        dr_err_r   <= dr_err_r;
      end
    end
  end

  // A response captured on the edge that enters reset must never be seen,
  // so reset masks the registered outputs while it is held.
  assign if_rvalid = if_rvalid_r & ~reset;
  assign if_rdata  = reset ? {DATA_W{1'b0}} : if_rdata_r;
  assign if_err    = if_err_r & ~reset;
  assign dr_rvalid = dr_rvalid_r & ~reset;
  assign dr_rdata  = reset ? {DATA_W{1'b0}} : dr_rdata_r;
  assign dr_err    = dr_err_r & ~reset;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Testbench for rom_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the arbitration and response rules.
module tb_rom_port_arbiter;

  localparam int ADDR_W     = 17;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clock;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;
  logic              dr_req;
  logic [ADDR_W-1:0] dr_addr;
  logic              dr_ready;
  logic              dr_rvalid;
  logic [DATA_W-1:0] dr_rdata;
  logic              dr_err;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  int passed = 0;
  int total  = 0;

  rom_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .dr_req(dr_req), .dr_addr(dr_addr), .dr_ready(dr_ready),
    .dr_rvalid(dr_rvalid), .dr_rdata(dr_rdata), .dr_err(dr_err),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM contents: a distinct word per index, derived arithmetically.
  function automatic logic [31:0] rom_fn(input logic [14:0] idx);
    return {idx ^ 15'h2B3C, 2'b10, idx};
  endfunction

  assign rom_data = rom_fn(rom_addr[16:2]);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int               m_wait = 0;      // consecutive refused DR cycles
  logic             m_if_v = 1'b0, m_dr_v = 1'b0;
  logic [31:0]      m_if_d = 32'h0, m_dr_d = 32'h0;
  logic             m_if_e = 1'b0, m_dr_e = 1'b0;

  always @(negedge clock) begin
    logic g_if, g_dr;
    logic [ADDR_W-1:0] a;
    g_if = 1'b0; g_dr = 1'b0;
    if (!reset) begin
      if (dr_req && m_wait >= STARVE_MAX) g_dr = 1'b1;
      else if (if_req) g_if = 1'b1;
      else if (dr_req) g_dr = 1'b1;
    end
    a = g_if ? if_addr : (g_dr ? dr_addr : 17'h0);
    check("m_if_ready", {31'h0, if_ready}, {31'h0, g_if});
    check("m_dr_ready", {31'h0, dr_ready}, {31'h0, g_dr});
    check("m_rom_addr", {15'h0, rom_addr}, {15'h0, a});
    check("m_if_rvalid", {31'h0, if_rvalid}, {31'h0, m_if_v & ~reset});
    check("m_dr_rvalid", {31'h0, dr_rvalid}, {31'h0, m_dr_v & ~reset});
    check("m_if_rdata", if_rdata, reset ? 32'h0 : m_if_d);
    check("m_dr_rdata", dr_rdata, reset ? 32'h0 : m_dr_d);
    check("m_if_err", {31'h0, if_err}, {31'h0, m_if_e & ~reset});
    check("m_dr_err", {31'h0, dr_err}, {31'h0, m_dr_e & ~reset});
    // state after the coming rising edge
    if (reset) begin
      m_wait = 0; m_if_v = 1'b0; m_dr_v = 1'b0;
      m_if_d = 32'h0; m_dr_d = 32'h0; m_if_e = 1'b0; m_dr_e = 1'b0;
    end else begin
      m_if_v = g_if;
      m_dr_v = g_dr;
      if (g_if) begin
        m_if_e = (if_addr % 4) != 0;
        m_if_d = m_if_e ? 32'h0 : rom_fn(if_addr / 4);
      end
      if (g_dr) begin
        m_dr_e = (dr_addr % 4) != 0;
        m_dr_d = m_dr_e ? 32'h0 : rom_fn(dr_addr / 4);
      end
      if (dr_req && g_if) m_wait = (m_wait + 1 > STARVE_MAX) ? STARVE_MAX : m_wait + 1;
      else m_wait = 0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    logic [ADDR_W-1:0] r;
    r = ADDR_W'($urandom);
    if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
    return r;
  endfunction

  logic if_rdy_q, dr_rdy_q;

  initial begin
    reset = 1'b1; if_req = 1'b1; dr_req = 1'b1; if_addr = 17'h0; dr_addr = 17'h0;
    tick();
    @(negedge clock);
    check("rst_if_ready", {31'h0, if_ready}, 32'h0);
    check("rst_dr_ready", {31'h0, dr_ready}, 32'h0);
    check("rst_if_rvalid", {31'h0, if_rvalid}, 32'h0);
    check("rst_dr_rdata", dr_rdata, 32'h0);

    // IF only, 0x0 / 0x4 / 0x8
    tick(); reset = 1'b0; dr_req = 1'b0; if_req = 1'b1; if_addr = 17'h0;
    @(negedge clock); check("t1_ready0", {31'h0, if_ready}, 32'h1);
    tick(); if_addr = 17'h4;
    @(negedge clock); check("t1_ready1", {31'h0, if_ready}, 32'h1);
    check("t1_rvalid_a", {31'h0, if_rvalid}, 32'h1);
    check("t1_rdata_a", if_rdata, 32'h5679_0000);
    tick(); if_addr = 17'h8;
    @(negedge clock); check("t1_rdata_b", if_rdata, 32'h567B_0001);
    check("t1_dr_rvalid", {31'h0, dr_rvalid}, 32'h0);
    tick(); if_req = 1'b0;
    @(negedge clock); check("t1_rdata_c", if_rdata, 32'h567D_0002);
    check("t1_rvalid_c", {31'h0, if_rvalid}, 32'h1);

    // DR only, 0x10
    tick(); dr_req = 1'b1; dr_addr = 17'h10;
    @(negedge clock); check("t3_dr_ready", {31'h0, dr_ready}, 32'h1);
    tick(); dr_req = 1'b0;
    @(negedge clock); check("t3_dr_rvalid", {31'h0, dr_rvalid}, 32'h1);
    check("t3_dr_rdata", dr_rdata, 32'h5671_0004);
    check("t3_dr_err", {31'h0, dr_err}, 32'h0);

    // Misaligned fetch 0x6
    tick(); if_req = 1'b1; if_addr = 17'h6;
    @(negedge clock); check("t4_ready", {31'h0, if_ready}, 32'h1);
    tick(); if_req = 1'b0;
    @(negedge clock); check("t4_err", {31'h0, if_err}, 32'h1);
    check("t4_rdata", if_rdata, 32'h0);
    check("t4_rvalid", {31'h0, if_rvalid}, 32'h1);

    // Both requesting continuously: DR every 5th cycle
    tick(); if_req = 1'b1; if_addr = 17'h100; dr_req = 1'b1; dr_addr = 17'h204;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("t2_dr_ready", {31'h0, dr_ready}, (i % 5 == 4) ? 32'h1 : 32'h0);
      check("t2_if_ready", {31'h0, if_ready}, (i % 5 == 4) ? 32'h0 : 32'h1);
      tick();
    end

    // DR 3 cycles, drop 1, re-assert: granted on 5th cycle after re-assertion
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      tick();
    end
    dr_req = 1'b0;
    @(negedge clock);
    tick(); dr_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t6_dr_ready", {31'h0, dr_ready}, (i == 4) ? 32'h1 : 32'h0);
      tick();
    end

    // Reset in the cycle after a DR handshake
    if_req = 1'b0; dr_req = 1'b1; dr_addr = 17'h40;
    @(negedge clock); check("t5_dr_ready", {31'h0, dr_ready}, 32'h1);
    tick(); reset = 1'b1; dr_req = 1'b0;
    @(negedge clock);
    check("t5_dr_rvalid", {31'h0, dr_rvalid}, 32'h0);
    check("t5_dr_rdata", dr_rdata, 32'h0);
    check("t5_if_rdata", if_rdata, 32'h0);
    tick(); reset = 1'b0; if_req = 1'b1; dr_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t5_if_first", {31'h0, if_ready}, (i < 4) ? 32'h1 : 32'h0);
      tick();
    end

    // Randomized traffic, mostly protocol-compliant, occasional drops/resets
    if_rdy_q = 1'b0; dr_rdy_q = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (!(if_req && !if_rdy_q) || $urandom_range(0, 15) == 0) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = rand_addr();
      end
      if (!(dr_req && !dr_rdy_q) || $urandom_range(0, 15) == 0) begin
        dr_req  = ($urandom_range(0, 1) != 0);
        dr_addr = rand_addr();
      end
      @(negedge clock);
      if_rdy_q = if_ready;
      dr_rdy_q = dr_ready;
      tick();
    end

    reset = 1'b0; if_req = 1'b0; dr_req = 1'b0;
    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
